// File: rtl/rv2t_mem_controller_pkg.sv
// rv2t_mem_controller_pkg: shared widths, FSM encodings and request record
// Contents: XLEN/PC_BITWIDTH widths, IDLE/ACCESS state codes, req_t pending-request record
package rv2t_mem_controller_pkg;
   localparam int XLEN = 32;
   localparam int PC_BITWIDTH = 32;
   localparam logic [0:0] STATE_IDLE = 1'b0;
   localparam logic [0:0] STATE_ACCESS = 1'b1;
   typedef struct packed {
      logic we;
      logic [3:0] be;
      logic [PC_BITWIDTH-1:0] addr;
      logic [XLEN-1:0] wdata;
   } req_t;
endpackage

// File: rtl/rv2t_mem_controller_if.sv
// rv2t_mem_controller_if: fetch, load/store and SRAM signals of the memory controller
// Groups: fetch_read_* (fetch port), data_* (load/store port), sram_* (SRAM port)
// Modports: slave = controller side, master = requesters plus SRAM side
interface rv2t_mem_controller_if #(parameter int SRAM_ADDR_BITS = 14);
   import rv2t_mem_controller_pkg::*;
   logic fetch_read_enable;
   logic [PC_BITWIDTH-1:0] fetch_read_addr;
   logic fetch_read_done;
   logic [XLEN-1:0] fetch_read_data;
   logic data_enable;
   logic data_we;
   logic [PC_BITWIDTH-1:0] data_addr;
   logic [3:0] data_byte_en;
   logic [XLEN-1:0] data_wdata;
   logic data_done;
   logic [XLEN-1:0] data_rdata;
   logic data_overrun;
   logic sram_ce;
   logic sram_we;
   logic [SRAM_ADDR_BITS-1:0] sram_addr;
   logic [3:0] sram_be;
   logic [XLEN-1:0] sram_wdata;
   logic [XLEN-1:0] sram_rdata;
   modport slave (
      input fetch_read_enable, fetch_read_addr, data_enable, data_we, data_addr, data_byte_en, data_wdata, sram_rdata,
      output fetch_read_done, fetch_read_data, data_done, data_rdata, data_overrun,
      output sram_ce, sram_we, sram_addr, sram_be, sram_wdata
   );
   modport master (
      output fetch_read_enable, fetch_read_addr, data_enable, data_we, data_addr, data_byte_en, data_wdata, sram_rdata,
      input fetch_read_done, fetch_read_data, data_done, data_rdata, data_overrun,
      input sram_ce, sram_we, sram_addr, sram_be, sram_wdata
   );
endinterface

// File: rtl/rv2t_mem_arbiter.sv
// rv2t_mem_arbiter: per-port pending slots and fetch/data grant selection
// Inputs: clk, reset_n (sync, active-low), can_grant (controller idle), fetch/data requests
// Outputs: grant, grant_data (1 = data port wins), grant_req (winning request), data_overrun (sticky)
module rv2t_mem_arbiter
   import rv2t_mem_controller_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic can_grant,
   input  logic fetch_enable,
   input  logic [PC_BITWIDTH-1:0] fetch_addr,
   input  logic data_enable,
   input  req_t data_req,
   output logic grant,
   output logic grant_data,
   output req_t grant_req,
   output logic data_overrun
);
   req_t fetch_in, fetch_slot, data_slot;
   logic fetch_valid, data_valid, last_data, fetch_cand, data_cand;
   assign fetch_in = '{1'b0, 4'hF, fetch_addr, {XLEN{1'b0}}};
   assign fetch_cand = fetch_enable | fetch_valid;
   assign data_cand = data_enable | data_valid;
   assign grant_data = data_cand & (~fetch_cand | ~last_data);
   assign grant = can_grant & (fetch_cand | data_cand);
   // newest fetch address wins (redirect); an occupied data slot is older than any incoming data request
   assign grant_req = grant_data ? (data_valid ? data_slot : data_req) : (fetch_enable ? fetch_in : fetch_slot);
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fetch_valid <= 1'b0;
         data_valid <= 1'b0;
         last_data <= 1'b0;
         data_overrun <= 1'b0;
         fetch_slot <= '0;
         data_slot <= '0;
      end else begin
         if (grant && !grant_data) fetch_valid <= 1'b0;
         else if (fetch_enable) begin
            fetch_valid <= 1'b1;
            fetch_slot <= fetch_in;
         end
         if (grant && grant_data) data_valid <= 1'b0;
         else if (data_enable && !data_valid) begin
            data_valid <= 1'b1;
            data_slot <= data_req;
         end
         if (data_enable && data_valid) data_overrun <= 1'b1;
         // only contested grants move the alternation pointer
         if (grant && fetch_cand && data_cand) last_data <= grant_data;
      end
   end
endmodule

// File: rtl/rv2t_mem_controller.sv
// rv2t_mem_controller: single-port SRAM controller arbitrating RV2T fetch and load/store traffic
// Ports: clk, reset_n (sync, active-low), bus (rv2t_mem_controller_if.slave: fetch, data and SRAM groups)
// Params: SRAM_ADDR_BITS (SRAM word-address width), SRAM_LATENCY (ce-to-rdata cycles, 1..4)
module rv2t_mem_controller
   import rv2t_mem_controller_pkg::*;
#(
   parameter int SRAM_ADDR_BITS = 14,
   parameter int SRAM_LATENCY = 1
)(
   input  logic clk,
   input  logic reset_n,
   rv2t_mem_controller_if.slave bus
);
   localparam logic [2:0] LAT = 3'(SRAM_LATENCY);
   logic [0:0] state;
   logic [2:0] cnt;
   logic cur_data, cur_we, cancel, grant, grant_data, can_grant, active, last, fetch_done, data_done, unused;
   logic [XLEN-1:0] fetch_q, data_q;
   req_t data_req, grant_req;
   assign data_req = '{bus.data_we, bus.data_byte_en, bus.data_addr, bus.data_wdata};
   assign can_grant = reset_n && state == STATE_IDLE;
   assign active = reset_n && state == STATE_ACCESS;
   assign last = cnt == LAT;
   // a fetch arriving at any point of an in-flight fetch discards its result
   assign fetch_done = active && !cur_data && last && !cancel && !bus.fetch_read_enable;
   assign data_done = active && cur_data && (cur_we ? cnt == 3'd1 : last);
   rv2t_mem_arbiter u_arb (
      .clk(clk),
      .reset_n(reset_n),
      .can_grant(can_grant),
      .fetch_enable(bus.fetch_read_enable),
      .fetch_addr(bus.fetch_read_addr),
      .data_enable(bus.data_enable),
      .data_req(data_req),
      .grant(grant),
      .grant_data(grant_data),
      .grant_req(grant_req),
      .data_overrun(bus.data_overrun)
   );
   assign bus.sram_ce = grant;
   assign bus.sram_we = grant && grant_req.we;
   assign bus.sram_addr = grant ? grant_req.addr[SRAM_ADDR_BITS+1:2] : '0;
   assign bus.sram_be = grant ? (grant_req.we ? grant_req.be : 4'hF) : 4'h0;
   assign bus.sram_wdata = grant && grant_req.we ? grant_req.wdata : '0;
   assign bus.fetch_read_done = fetch_done;
   assign bus.fetch_read_data = fetch_done ? bus.sram_rdata : fetch_q;
   assign bus.data_done = data_done;
   assign bus.data_rdata = data_done && !cur_we ? bus.sram_rdata : data_q;
   assign unused = ^grant_req.addr;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= STATE_IDLE;
         cnt <= 3'd0;
         cur_data <= 1'b0;
         cur_we <= 1'b0;
         cancel <= 1'b0;
         fetch_q <= '0;
         data_q <= '0;
      end else if (state == STATE_IDLE) begin
         if (grant) begin
            state <= STATE_ACCESS;
            cnt <= 3'd1;
            cur_data <= grant_data;
            cur_we <= grant_req.we;
            cancel <= 1'b0;
         end
      end else begin
         cnt <= cnt + 3'd1;
         if (!cur_data && bus.fetch_read_enable) cancel <= 1'b1;
         if (last) state <= STATE_IDLE;
         if (fetch_done) fetch_q <= bus.sram_rdata;
         if (data_done && !cur_we) data_q <= bus.sram_rdata;
      end
   end
endmodule

// File: tb/tb_rv2t_mem_controller.sv
// tb_rv2t_mem_controller: directed checks of rv2t_mem_controller at SRAM latencies 1, 2 and 3
module tb_rv2t_mem_controller;
   import rv2t_mem_controller_pkg::*;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int checks = 0;
   int failures = 0;
   logic [31:0] p1;
   logic [31:0] p2 [2];
   logic [31:0] p3 [3];
   logic [31:0] mem2 [16];
   always #5 clk = ~clk;
   rv2t_mem_controller_if b1 ();
   rv2t_mem_controller_if b2 ();
   rv2t_mem_controller_if b3 ();
   rv2t_mem_controller #(.SRAM_LATENCY(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));
   rv2t_mem_controller #(.SRAM_LATENCY(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(b2));
   rv2t_mem_controller #(.SRAM_LATENCY(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(b3));
   // SRAM models: b1 and b3 are fixed patterns (word 0x40 of b1 holds 0x13), b2 is a writable 16-word RAM
   always @(posedge clk) begin
      p1 <= b1.sram_addr == 14'h40 ? 32'h0000_0013 : 32'hA100_0000 | 32'(b1.sram_addr);
      p3[0] <= 32'hA300_0000 | 32'(b3.sram_addr);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
      p2[0] <= mem2[b2.sram_addr[3:0]];
      p2[1] <= p2[0];
      if (!reset_n) for (int i = 0; i < 16; i++) mem2[i] <= '0;
      else if (b2.sram_ce && b2.sram_we)
         for (int j = 0; j < 4; j++) if (b2.sram_be[j]) mem2[b2.sram_addr[3:0]][8*j +: 8] <= b2.sram_wdata[8*j +: 8];
   end
   assign b1.sram_rdata = p1;
   assign b2.sram_rdata = p2[1];
   assign b3.sram_rdata = p3[2];
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic mid;
      @(negedge clk);
   endtask
   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) tick();
      mid();
      checks++; if (b1.sram_ce !== 1'b0) begin failures++; $display("FAIL reset_ce got=%0h exp=0", b1.sram_ce); end
      checks++; if (b1.fetch_read_done !== 1'b0) begin failures++; $display("FAIL reset_fdone got=%0h exp=0", b1.fetch_read_done); end
      checks++; if (b2.data_done !== 1'b0) begin failures++; $display("FAIL reset_ddone got=%0h exp=0", b2.data_done); end
      checks++; if (b3.data_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0h exp=0", b3.data_overrun); end
      checks++; if (b1.fetch_read_data !== 32'h0) begin failures++; $display("FAIL reset_fdata got=%0h exp=0", b1.fetch_read_data); end
      tick();
      reset_n = 1'b1;
   endtask
   task automatic test_fetch;
      tick();
      b1.fetch_read_enable = 1'b1; b1.fetch_read_addr = 32'h100;
      mid();
      checks++; if (b1.sram_ce !== 1'b1) begin failures++; $display("FAIL fetch_ce got=%0h exp=1", b1.sram_ce); end
      checks++; if (b1.sram_addr !== 14'h40) begin failures++; $display("FAIL fetch_addr got=%0h exp=40", b1.sram_addr); end
      checks++; if (b1.sram_be !== 4'hF || b1.sram_we !== 1'b0) begin failures++; $display("FAIL fetch_be_we got=%0h/%0h exp=f/0", b1.sram_be, b1.sram_we); end
      tick();
      b1.fetch_read_enable = 1'b0;
      mid();
      checks++; if (b1.fetch_read_done !== 1'b1) begin failures++; $display("FAIL fetch_done got=%0h exp=1", b1.fetch_read_done); end
      checks++; if (b1.fetch_read_data !== 32'h13) begin failures++; $display("FAIL fetch_data got=%0h exp=13", b1.fetch_read_data); end
      tick();
      mid();
      checks++; if (b1.fetch_read_done !== 1'b0) begin failures++; $display("FAIL fetch_done_once got=%0h exp=0", b1.fetch_read_done); end
      checks++; if (b1.fetch_read_data !== 32'h13) begin failures++; $display("FAIL fetch_hold got=%0h exp=13", b1.fetch_read_data); end
      checks++; if (b1.sram_ce !== 1'b0) begin failures++; $display("FAIL fetch_idle_ce got=%0h exp=0", b1.sram_ce); end
   endtask
   task automatic test_store_load;
      tick();
      b2.data_enable = 1'b1; b2.data_we = 1'b1; b2.data_addr = 32'h20; b2.data_byte_en = 4'b0011; b2.data_wdata = 32'hDEADBEEF;
      mid();
      checks++; if (b2.sram_ce !== 1'b1 || b2.sram_we !== 1'b1) begin failures++; $display("FAIL st_ce_we got=%0h/%0h exp=1/1", b2.sram_ce, b2.sram_we); end
      checks++; if (b2.sram_addr !== 14'h8 || b2.sram_be !== 4'b0011) begin failures++; $display("FAIL st_addr_be got=%0h/%0h exp=8/3", b2.sram_addr, b2.sram_be); end
      checks++; if (b2.sram_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL st_wdata got=%0h exp=deadbeef", b2.sram_wdata); end
      tick();
      b2.data_enable = 1'b0;
      mid();
      checks++; if (b2.data_done !== 1'b1) begin failures++; $display("FAIL st_done got=%0h exp=1", b2.data_done); end
      tick();
      mid();
      checks++; if (b2.data_done !== 1'b0) begin failures++; $display("FAIL st_done_once got=%0h exp=0", b2.data_done); end
      tick();
      b2.data_enable = 1'b1; b2.data_we = 1'b0; b2.data_addr = 32'h20;
      mid();
      checks++; if (b2.sram_ce !== 1'b1 || b2.sram_we !== 1'b0 || b2.sram_be !== 4'hF) begin failures++; $display("FAIL ld_grant got=%0h/%0h/%0h exp=1/0/f", b2.sram_ce, b2.sram_we, b2.sram_be); end
      tick();
      b2.data_enable = 1'b0;
      mid();
      checks++; if (b2.data_done !== 1'b0) begin failures++; $display("FAIL ld_early got=%0h exp=0", b2.data_done); end
      tick();
      mid();
      checks++; if (b2.data_done !== 1'b1) begin failures++; $display("FAIL ld_done got=%0h exp=1", b2.data_done); end
      checks++; if (b2.data_rdata !== 32'h0000BEEF) begin failures++; $display("FAIL ld_data got=%0h exp=beef", b2.data_rdata); end
      tick();
      mid();
      checks++; if (b2.data_done !== 1'b0 || b2.data_rdata !== 32'h0000BEEF) begin failures++; $display("FAIL ld_hold got=%0h/%0h exp=0/beef", b2.data_done, b2.data_rdata); end
   endtask
   task automatic test_tie;
      tick();
      b1.fetch_read_enable = 1'b1; b1.fetch_read_addr = 32'h04;
      b1.data_enable = 1'b1; b1.data_we = 1'b0; b1.data_addr = 32'h08;
      mid();
      checks++; if (b1.sram_ce !== 1'b1 || b1.sram_addr !== 14'h2) begin failures++; $display("FAIL tie1_grant got=%0h/%0h exp=1/2", b1.sram_ce, b1.sram_addr); end
      tick();
      b1.fetch_read_enable = 1'b0; b1.data_enable = 1'b0;
      mid();
      checks++; if (b1.data_done !== 1'b1 || b1.data_rdata !== 32'hA1000002) begin failures++; $display("FAIL tie1_data got=%0h/%0h exp=1/a1000002", b1.data_done, b1.data_rdata); end
      checks++; if (b1.fetch_read_done !== 1'b0 || b1.sram_ce !== 1'b0) begin failures++; $display("FAIL tie1_busy got=%0h/%0h exp=0/0", b1.fetch_read_done, b1.sram_ce); end
      tick();
      mid();
      checks++; if (b1.sram_ce !== 1'b1 || b1.sram_addr !== 14'h1) begin failures++; $display("FAIL tie1_fgrant got=%0h/%0h exp=1/1", b1.sram_ce, b1.sram_addr); end
      tick();
      mid();
      checks++; if (b1.fetch_read_done !== 1'b1 || b1.fetch_read_data !== 32'hA1000001) begin failures++; $display("FAIL tie1_fetch got=%0h/%0h exp=1/a1000001", b1.fetch_read_done, b1.fetch_read_data); end
      tick();
      b1.fetch_read_enable = 1'b1; b1.fetch_read_addr = 32'h0C;
      b1.data_enable = 1'b1; b1.data_addr = 32'h10;
      mid();
      checks++; if (b1.sram_ce !== 1'b1 || b1.sram_addr !== 14'h3) begin failures++; $display("FAIL tie2_grant got=%0h/%0h exp=1/3", b1.sram_ce, b1.sram_addr); end
      tick();
      b1.fetch_read_enable = 1'b0; b1.data_enable = 1'b0;
      mid();
      checks++; if (b1.fetch_read_done !== 1'b1 || b1.fetch_read_data !== 32'hA1000003) begin failures++; $display("FAIL tie2_fetch got=%0h/%0h exp=1/a1000003", b1.fetch_read_done, b1.fetch_read_data); end
      tick();
      mid();
      checks++; if (b1.sram_ce !== 1'b1 || b1.sram_addr !== 14'h4) begin failures++; $display("FAIL tie2_dgrant got=%0h/%0h exp=1/4", b1.sram_ce, b1.sram_addr); end
      tick();
      mid();
      checks++; if (b1.data_done !== 1'b1 || b1.data_rdata !== 32'hA1000004) begin failures++; $display("FAIL tie2_data got=%0h/%0h exp=1/a1000004", b1.data_done, b1.data_rdata); end
   endtask
   task automatic test_redirect;
      int nd, nc;
      logic [31:0] dv;
      logic [13:0] ca;
      nd = 0; nc = 0; dv = '0; ca = '0;
      tick();
      b3.fetch_read_enable = 1'b1; b3.fetch_read_addr = 32'h0;
      mid();
      checks++; if (b3.sram_ce !== 1'b1 || b3.sram_addr !== 14'h0) begin failures++; $display("FAIL redir_grant got=%0h/%0h exp=1/0", b3.sram_ce, b3.sram_addr); end
      tick();
      b3.fetch_read_addr = 32'h80;
      mid();
      checks++; if (b3.sram_ce !== 1'b0 || b3.fetch_read_done !== 1'b0) begin failures++; $display("FAIL redir_busy got=%0h/%0h exp=0/0", b3.sram_ce, b3.fetch_read_done); end
      tick();
      b3.fetch_read_enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         mid();
         if (b3.fetch_read_done) begin nd++; dv = b3.fetch_read_data; end
         if (b3.sram_ce) begin nc++; ca = b3.sram_addr; end
         tick();
      end
      checks++; if (nd != 1) begin failures++; $display("FAIL redir_done_count got=%0d exp=1", nd); end
      checks++; if (dv !== 32'hA3000020) begin failures++; $display("FAIL redir_data got=%0h exp=a3000020", dv); end
      checks++; if (nc != 1 || ca !== 14'h20) begin failures++; $display("FAIL redir_reissue got=%0d/%0h exp=1/20", nc, ca); end
   endtask
   task automatic test_overrun;
      int nd, nc;
      logic [31:0] dv;
      nd = 0; nc = 0; dv = '0;
      tick();
      b1.fetch_read_enable = 1'b1; b1.fetch_read_addr = 32'h20;
      mid();
      checks++; if (b1.sram_ce !== 1'b1) begin failures++; $display("FAIL ovr_fgrant got=%0h exp=1", b1.sram_ce); end
      tick();
      b1.fetch_read_enable = 1'b0;
      b1.data_enable = 1'b1; b1.data_we = 1'b0; b1.data_addr = 32'h14;
      mid();
      checks++; if (b1.fetch_read_done !== 1'b1 || b1.data_overrun !== 1'b0) begin failures++; $display("FAIL ovr_first got=%0h/%0h exp=1/0", b1.fetch_read_done, b1.data_overrun); end
      tick();
      b1.data_addr = 32'h18;
      mid();
      checks++; if (b1.sram_ce !== 1'b1 || b1.sram_addr !== 14'h5) begin failures++; $display("FAIL ovr_grant got=%0h/%0h exp=1/5", b1.sram_ce, b1.sram_addr); end
      tick();
      b1.data_enable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         mid();
         if (b1.data_done) begin nd++; dv = b1.data_rdata; end
         if (b1.sram_ce) nc++;
         tick();
      end
      checks++; if (nd != 1 || dv !== 32'hA1000005) begin failures++; $display("FAIL ovr_done got=%0d/%0h exp=1/a1000005", nd, dv); end
      checks++; if (nc != 0) begin failures++; $display("FAIL ovr_dropped got=%0d exp=0", nc); end
      checks++; if (b1.data_overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%0h exp=1", b1.data_overrun); end
   endtask
   task automatic test_reset_mid;
      int nd;
      logic [31:0] dv;
      nd = 0; dv = '0;
      tick();
      b3.fetch_read_enable = 1'b1; b3.fetch_read_addr = 32'h100;
      mid();
      checks++; if (b3.sram_ce !== 1'b1) begin failures++; $display("FAIL rmid_grant got=%0h exp=1", b3.sram_ce); end
      tick();
      b3.fetch_read_enable = 1'b0;
      tick();
      reset_n = 1'b0;
      mid();
      checks++; if (b3.fetch_read_done !== 1'b0 || b3.sram_ce !== 1'b0) begin failures++; $display("FAIL rmid_during got=%0h/%0h exp=0/0", b3.fetch_read_done, b3.sram_ce); end
      tick();
      reset_n = 1'b1;
      mid();
      checks++; if (b3.fetch_read_data !== 32'h0 || b3.fetch_read_done !== 1'b0) begin failures++; $display("FAIL rmid_after got=%0h/%0h exp=0/0", b3.fetch_read_data, b3.fetch_read_done); end
      checks++; if (b1.data_overrun !== 1'b0) begin failures++; $display("FAIL rmid_overrun got=%0h exp=0", b1.data_overrun); end
      for (int i = 0; i < 5; i++) begin
         tick();
         mid();
         if (b3.fetch_read_done) nd++;
      end
      checks++; if (nd != 0) begin failures++; $display("FAIL rmid_no_done got=%0d exp=0", nd); end
      tick();
      b3.fetch_read_enable = 1'b1; b3.fetch_read_addr = 32'h04;
      mid();
      checks++; if (b3.sram_ce !== 1'b1 || b3.sram_addr !== 14'h1) begin failures++; $display("FAIL rmid_fresh_grant got=%0h/%0h exp=1/1", b3.sram_ce, b3.sram_addr); end
      tick();
      b3.fetch_read_enable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         mid();
         if (b3.fetch_read_done) begin nd++; dv = b3.fetch_read_data; end
         tick();
      end
      checks++; if (nd != 1 || dv !== 32'hA3000001) begin failures++; $display("FAIL rmid_fresh got=%0d/%0h exp=1/a3000001", nd, dv); end
   endtask
   initial begin
      b1.fetch_read_enable = 1'b0; b1.fetch_read_addr = '0; b1.data_enable = 1'b0; b1.data_we = 1'b0;
      b1.data_addr = '0; b1.data_byte_en = 4'h0; b1.data_wdata = '0;
      b2.fetch_read_enable = 1'b0; b2.fetch_read_addr = '0; b2.data_enable = 1'b0; b2.data_we = 1'b0;
      b2.data_addr = '0; b2.data_byte_en = 4'h0; b2.data_wdata = '0;
      b3.fetch_read_enable = 1'b0; b3.fetch_read_addr = '0; b3.data_enable = 1'b0; b3.data_we = 1'b0;
      b3.data_addr = '0; b3.data_byte_en = 4'h0; b3.data_wdata = '0;
      test_reset();
      test_fetch();
      test_store_load();
      test_tie();
      test_redirect();
      test_overrun();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
